// File: rtl/i2c_slave_transmit_controller_if.sv
// Handshake, byte-writer, bit-reader and status signals of the I2C
// slave-transmit sequencer, grouped so the controller and its user share one bundle.
interface i2c_slave_transmit_controller_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   start;
  logic                   bus_stop;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   wb_enable;
  logic                   wb_data;
  logic                   wb_load;
  logic                   wb_finish;
  logic                   rb_enable;
  logic                   rb_data;
  logic                   rb_finish;
  logic                   scl_stretch;
  logic                   busy;
  logic                   done;
  logic                   abort;
  logic                   nack;
  logic [COUNT_WIDTH-1:0] byte_count;

  modport slave (
    input  start, bus_stop, tx_data, tx_valid, wb_load, wb_finish, rb_data, rb_finish,
    output tx_ready, wb_enable, wb_data, rb_enable, scl_stretch, busy, done, abort,
           nack, byte_count
  );

  modport master (
    output start, bus_stop, tx_data, tx_valid, wb_load, wb_finish, rb_data, rb_finish,
    input  tx_ready, wb_enable, wb_data, rb_enable, scl_stretch, busy, done, abort,
           nack, byte_count
  );
endinterface

// File: rtl/i2c_slave_transmit_controller.sv
// Slave-transmit (master-read) sequencer: fetches bytes from user logic, feeds the
// serial byte writer, collects the master's ACK and stretches SCL while starved.
module i2c_slave_transmit_controller #(
  parameter int COUNT_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                            clock,
  input logic                            reset_n,
  i2c_slave_transmit_controller_if.slave bus
);

  localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1)
                                                               : {TMO_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  state_t                 state_q,   state_d;
  logic [7:0]             shift_q,   shift_d;
  logic [COUNT_WIDTH-1:0] count_q,   count_d;
  logic                   nack_q,    nack_d;
  logic                   stretch_q, stretch_d;
  logic                   busy_q,    busy_d;
  logic [TMO_W-1:0]       tmo_q,     tmo_d;

  logic load_s;
  logic rb_en_s;
  logic done_s;
  logic abort_s;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (v == {COUNT_WIDTH{1'b1}}) begin
      return v;
    end else begin
      return v + COUNT_WIDTH'(1);
    end
  endfunction

  // Next-state, datapath updates and per-cycle strobes; bus_stop outranks every other event.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    nack_d  = nack_q;
    tmo_d   = {TMO_W{1'b0}};
    load_s  = 1'b0;
    rb_en_s = 1'b0;
    done_s  = 1'b0;
    abort_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.bus_stop) begin
          count_d = {COUNT_WIDTH{1'b0}};
          nack_d  = 1'b0;
          load_s  = bus.tx_valid;
          shift_d = bus.tx_valid ? bus.tx_data : shift_q;
          state_d = bus.tx_valid ? ST_SEND : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (bus.bus_stop) begin
          abort_s = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.tx_valid) begin
          load_s  = 1'b1;
          shift_d = bus.tx_data;
          state_d = ST_SEND;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          abort_s = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_SEND: begin
        if (bus.bus_stop) begin
          abort_s = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.wb_finish) begin
          count_d = sat_inc(count_q);
          rb_en_s = 1'b1;
          state_d = ST_ACK;
        end else if (bus.wb_load) begin
          shift_d = {shift_q[6:0], 1'b0};
        end else begin
          shift_d = shift_q;
        end
      end

      ST_ACK: begin
        if (bus.bus_stop) begin
          abort_s = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.rb_finish && bus.rb_data) begin
          nack_d  = 1'b1;
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.rb_finish) begin
          load_s  = bus.tx_valid;
          shift_d = bus.tx_valid ? bus.tx_data : shift_q;
          state_d = bus.tx_valid ? ST_SEND : ST_WAIT;
        end else begin
          state_d = ST_ACK;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    stretch_d = (state_d == ST_WAIT);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and status registers; reset drops SCL stretching immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      count_q   <= {COUNT_WIDTH{1'b0}};
      nack_q    <= 1'b0;
      stretch_q <= 1'b0;
      busy_q    <= 1'b0;
      tmo_q     <= {TMO_W{1'b0}};
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      nack_q    <= nack_d;
      stretch_q <= stretch_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
    end
  end

  // The writer sees the new MSB already in the cycle the byte is accepted.
  assign bus.tx_ready    = load_s;
  assign bus.wb_enable   = load_s;
  assign bus.wb_data     = load_s ? bus.tx_data[7] : shift_q[7];
  assign bus.rb_enable   = rb_en_s;
  assign bus.scl_stretch = stretch_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_s;
  assign bus.abort       = abort_s;
  assign bus.nack        = nack_q;
  assign bus.byte_count  = count_q;

endmodule

// File: doc/i2c_slave_transmit_controller.md
Name: i2c_slave_transmit_controller

Overview:
- Sequences the slave-transmit (master-read) phase of an I2C slave.
- Drives an external slave byte writer for the data bits and an external slave bit reader for the master's ACK/NACK.
- Fetches bytes from user logic with a valid/ready handshake.
- Stretches SCL while no byte is available, and ends the transfer on master NACK, bus STOP/repeated START, or stretch timeout.

Parameters:
- COUNT_WIDTH, 8: width of byte_count; the count saturates at 2^COUNT_WIDTH-1.
- TIMEOUT_CYCLES, 1024: maximum clock cycles spent stretching before abort; 0 disables the timeout.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  pulse at the SCL falling edge ending the address ACK (address matched, R/W=1)
- bus_stop  input  1  pulse on detected STOP or repeated START
- tx_data  input  8  next byte to transmit
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  byte accepted this cycle
- wb_enable  output  1  enable pulse to the byte writer
- wb_data  output  1  serial bit to the byte writer (MSB first)
- wb_load  input  1  byte writer consumed the current bit
- wb_finish  input  1  byte writer finished 8 bits (coincides with the SCL falling edge after bit 0)
- rb_enable  output  1  enable pulse to the bit reader for the ACK slot
- rb_data  input  1  sampled ACK bit (0=ACK, 1=NACK)
- rb_finish  input  1  ACK slot done (coincides with the SCL falling edge after the ACK bit)
- scl_stretch  output  1  hold SCL low
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse: transfer ended by NACK
- abort  output  1  one-cycle pulse: ended by bus_stop or timeout
- nack  output  1  sticky: last transfer ended by NACK
- byte_count  output  COUNT_WIDTH  bytes fully shifted out in the current or last transfer

Behaviour:
- Reset values: all outputs 0, byte_count 0, state IDLE, shift register 0, timeout counter 0.
- The design uses one clock. Reset is asynchronous and active-low; it forces IDLE immediately from any state.
- States: IDLE, WAIT, SEND, ACK.
- Fetch rule (the same rule applies in IDLE on start and in ACK on ACK):
  - If tx_valid=1: tx_ready=1 and wb_enable=1 combinationally in that cycle. tx_data is loaded into the shift register on the next edge. Go to SEND.
  - If tx_valid=0: go to WAIT.
- wb_data = tx_data[7] in the load cycle, otherwise shift_reg[7]. This gives the writer a valid MSB from the enable cycle onward.
- IDLE:
  - busy=0.
  - On start: clear byte_count and nack, then apply the fetch rule.
  - start while not IDLE is ignored.
- WAIT:
  - busy=1, scl_stretch=1 (registered; asserted from the first WAIT cycle).
  - Timeout counter increments each cycle.
  - On tx_valid: perform the load as above (tx_ready=1, wb_enable=1, load shift register), go to SEND, release scl_stretch next cycle.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 without tx_valid: abort=1, release stretch, go to IDLE.
  - The counter clears on leaving WAIT.
- SEND:
  - On each wb_load: shift the register left by 1.
  - On wb_finish: increment byte_count (saturating), assert rb_enable the same cycle, go to ACK.
- ACK:
  - On rb_finish with rb_data=0: apply the fetch rule.
  - On rb_finish with rb_data=1: nack=1, done=1, go to IDLE. No tx_ready is issued.
- bus_stop in any non-IDLE state:
  - Next state IDLE, abort=1, scl_stretch=0.
  - No tx_ready or wb_enable that cycle.
  - bus_stop wins over a simultaneous rb_finish, wb_finish or tx_valid. byte_count is not incremented.
- bus_stop in IDLE: no effect, no abort.
- start together with bus_stop in IDLE: start is ignored.
- tx_ready is only ever asserted together with wb_enable. At most one byte is accepted per ACK slot.
- done, abort and tx_ready are mutually exclusive in any cycle.

Test Plan:
- Single byte, NACK: tx_valid=1 with 0xA5 held, start pulse. Required: tx_ready and wb_enable in the same cycle; wb_data sequence 1,0,1,0,0,1,0,1 across wb_load; rb_enable on wb_finish; rb_data=1 at rb_finish gives done=1, nack=1, byte_count=1, state IDLE.
- Three bytes, ACK,ACK,NACK: bytes 0x01, 0x80, 0xFF are always valid. Required: three tx_ready pulses, each coinciding with rb_finish (or start for the first); byte_count=3; done once.
- Stretch: ACK after byte 1 with tx_valid=0 for 50 cycles. Required: scl_stretch=1 for those cycles, no wb_enable. On tx_valid: tx_ready=wb_enable=1, scl_stretch=0 next cycle, transfer continues.
- Timeout: TIMEOUT_CYCLES=16, start with tx_valid=0. Required: scl_stretch high for 16 cycles, then abort=1, busy=0, byte_count=0.
- bus_stop mid-byte: after 4 wb_load pulses, assert bus_stop coincident with a wb_load. Required: abort=1, IDLE next cycle, byte_count unchanged. A following start with tx_valid=1 begins a fresh transfer with byte_count cleared.
- Reset mid-WAIT: deassert reset_n asynchronously while in WAIT. Required: scl_stretch, busy and nack go to 0 immediately, without waiting for a clock edge.
